// File: rtl/jedro_1_alu_core_pkg.sv
// Shared widths, ALU opcode encoding ({instr[30], funct3}) and small helpers
// used by the jedro_1 execute-stage ALU.
package jedro_1_defines;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ALU_OP_WIDTH   = 4;
    localparam int SHAMT_WIDTH    = $clog2(DATA_WIDTH);

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    // Mirror a word so that a left shift can reuse the right-shift datapath.
    function automatic logic [DATA_WIDTH-1:0] bit_reverse(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = v[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/jedro_1_alu_core_shifter.sv
// Barrel shifter for SLL/SRL/SRA. One right-shift datapath; left shifts are
// done by mirroring the operand on the way in and the result on the way out.
module jedro_1_alu_shifter
    import jedro_1_defines::*;
(
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    input  logic                   left_i,
    input  logic                   arith_i,
    output logic [DATA_WIDTH-1:0]  res_o
);

    logic [DATA_WIDTH-1:0]   src_s;
    logic                    fill_s;
    logic [2*DATA_WIDTH-1:0] wide_s;
    logic [DATA_WIDTH-1:0]   mid_s;

    // Sign fill only applies to arithmetic right shifts.
    always_comb begin
        src_s  = left_i ? bit_reverse(data_i) : data_i;
        fill_s = arith_i & ~left_i & data_i[DATA_WIDTH-1];
        wide_s = {{DATA_WIDTH{fill_s}}, src_s} >> shamt_i;
        mid_s  = wide_s[DATA_WIDTH-1:0];
        res_o  = left_i ? bit_reverse(mid_s) : mid_s;
    end

endmodule

// File: rtl/jedro_1_alu_core.sv
// jedro_1 execute-stage integer ALU: one registered stage holding the result,
// operand-equality flag, signed-overflow flag and the writeback tag.
module jedro_1_alu_core
    import jedro_1_defines::*;
(
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [ALU_OP_WIDTH-1:0]   sel_i,
    input  logic [DATA_WIDTH-1:0]     op_a_i,
    input  logic [DATA_WIDTH-1:0]     op_b_i,
    input  logic [REG_ADDR_WIDTH-1:0] dest_addr_i,
    input  logic                      wb_i,
    output logic [DATA_WIDTH-1:0]     res_ro,
    output logic                      ops_eq_ro,
    output logic                      overflow_ro,
    output logic [REG_ADDR_WIDTH-1:0] dest_addr_ro,
    output logic                      wb_ro
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0]     res_d, res_q;
    logic                      ops_eq_d, ops_eq_q;
    logic                      overflow_d, overflow_q;
    logic [REG_ADDR_WIDTH-1:0] dest_addr_d, dest_addr_q;
    logic                      wb_d, wb_q;

    logic [DATA_WIDTH-1:0]     sum_s;
    logic [DATA_WIDTH-1:0]     diff_s;
    logic [DATA_WIDTH-1:0]     shift_res_s;
    logic                      shift_left_s;
    logic                      shift_arith_s;

    assign shift_left_s  = (sel_i == ALU_SLL);
    assign shift_arith_s = (sel_i == ALU_SRA);

    jedro_1_alu_shifter u_shifter (
        .data_i  (op_a_i),
        .shamt_i (op_b_i[SHAMT_WIDTH-1:0]),
        .left_i  (shift_left_s),
        .arith_i (shift_arith_s),
        .res_o   (shift_res_s)
    );

    // Next-value mux; unlisted opcodes yield zero result and no overflow.
    always_comb begin
        res_d       = '0;
        overflow_d  = 1'b0;
        sum_s       = op_a_i + op_b_i;
        diff_s      = op_a_i - op_b_i;
        ops_eq_d    = (op_a_i == op_b_i);
        dest_addr_d = dest_addr_i;
        wb_d        = wb_i;
        case (sel_i)
            ALU_ADD: begin
                res_d      = sum_s;
                overflow_d = (op_a_i[MSB] == op_b_i[MSB]) && (sum_s[MSB] != op_a_i[MSB]);
            end
            ALU_SUB: begin
                res_d      = diff_s;
                overflow_d = (op_a_i[MSB] != op_b_i[MSB]) && (diff_s[MSB] != op_a_i[MSB]);
            end
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                res_d = shift_res_s;
            end
            ALU_SLT: begin
                res_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
            end
            ALU_SLTU: begin
                res_d = {{(DATA_WIDTH-1){1'b0}}, (op_a_i < op_b_i)};
            end
            ALU_XOR: begin
                res_d = op_a_i ^ op_b_i;
            end
            ALU_OR: begin
                res_d = op_a_i | op_b_i;
            end
            ALU_AND: begin
                res_d = op_a_i & op_b_i;
            end
            default: begin
                res_d      = '0;
                overflow_d = 1'b0;
            end
        endcase
    end

    // Single output register stage, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            res_q       <= '0;
            ops_eq_q    <= 1'b0;
            overflow_q  <= 1'b0;
            dest_addr_q <= '0;
            wb_q        <= 1'b0;
        end else begin
            res_q       <= res_d;
            ops_eq_q    <= ops_eq_d;
            overflow_q  <= overflow_d;
            dest_addr_q <= dest_addr_d;
            wb_q        <= wb_d;
        end
    end

    assign res_ro       = res_q;
    assign ops_eq_ro    = ops_eq_q;
    assign overflow_ro  = overflow_q;
    assign dest_addr_ro = dest_addr_q;
    assign wb_ro        = wb_q;

endmodule

// File: tb/tb_jedro_1_alu_core.sv
// Self-checking bench for jedro_1_alu_core: behavioural RV32I ALU model,
// per-cycle compare process and hand-computed directed vectors.
module tb_jedro_1_alu_core;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [3:0]  sel_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [4:0]  dest_addr_i;
    logic        wb_i;
    logic [31:0] res_ro;
    logic        ops_eq_ro;
    logic        overflow_ro;
    logic [4:0]  dest_addr_ro;
    logic        wb_ro;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_res  = 32'd0;
    logic        exp_eq   = 1'b0;
    logic        exp_ovf  = 1'b0;
    logic [4:0]  exp_dest = 5'd0;
    logic        exp_wb   = 1'b0;

    jedro_1_alu_core dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .sel_i        (sel_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .dest_addr_i  (dest_addr_i),
        .wb_i         (wb_i),
        .res_ro       (res_ro),
        .ops_eq_ro    (ops_eq_ro),
        .overflow_ro  (overflow_ro),
        .dest_addr_ro (dest_addr_ro),
        .wb_ro        (wb_ro)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU: returns {overflow, result}, from plain integer arithmetic.
    function automatic logic [32:0] model(input logic [3:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic        ovf;
        longint      s;
        logic [4:0]  sh;
        r   = 32'd0;
        ovf = 1'b0;
        sh  = b[4:0];
        case (sel)
            4'd0: begin
                s   = longint'($signed(a)) + longint'($signed(b));
                r   = a + b;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd8: begin
                s   = longint'($signed(a)) - longint'($signed(b));
                r   = a - b;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1:  r = a << sh;
            4'd5:  r = a >> sh;
            4'd13: r = $signed(a) >>> sh;
            4'd2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  r = (a < b) ? 32'd1 : 32'd0;
            4'd4:  r = a ^ b;
            4'd6:  r = a | b;
            4'd7:  r = a & b;
            default: r = 32'd0;
        endcase
        return {ovf, r};
    endfunction

    // Model register: what the outputs must show after each edge.
    always @(posedge clk_i or negedge rstn_i) begin
        logic [32:0] m;
        if (!rstn_i) begin
            exp_res  = 32'd0;
            exp_eq   = 1'b0;
            exp_ovf  = 1'b0;
            exp_dest = 5'd0;
            exp_wb   = 1'b0;
        end else begin
            m        = model(sel_i, op_a_i, op_b_i);
            exp_res  = m[31:0];
            exp_ovf  = m[32];
            exp_eq   = (op_a_i == op_b_i);
            exp_dest = dest_addr_i;
            exp_wb   = wb_i;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk_i) begin
        chk("cyc_res",  res_ro,                exp_res);
        chk("cyc_eq",   {31'd0, ops_eq_ro},    {31'd0, exp_eq});
        chk("cyc_ovf",  {31'd0, overflow_ro},  {31'd0, exp_ovf});
        chk("cyc_dest", {27'd0, dest_addr_ro}, {27'd0, exp_dest});
        chk("cyc_wb",   {31'd0, wb_ro},        {31'd0, exp_wb});
    end

    // Apply inputs at a falling edge; on return the registered outputs reflect them.
    task automatic drive(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest, input logic wb);
        sel_i       = sel;
        op_a_i      = a;
        op_b_i      = b;
        dest_addr_i = dest;
        wb_i        = wb;
        @(negedge clk_i);
    endtask

    task automatic drive_rand();
        sel_i       = 4'($urandom);
        op_a_i      = $urandom;
        op_b_i      = $urandom;
        dest_addr_i = 5'($urandom);
        wb_i        = 1'($urandom);
    endtask

    initial begin
        rstn_i = 1'b1;
        drive_rand();
        #1 rstn_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            @(negedge clk_i);
            chk("rst_res",  res_ro, 32'd0);
            chk("rst_tag",  {25'd0, dest_addr_ro, wb_ro, ops_eq_ro, overflow_ro}, 32'd0);
        end
        rstn_i = 1'b1;

        drive(4'b0000, 32'd5, 32'd7, 5'd3, 1'b1);
        chk("add_res", res_ro, 32'd12);
        chk("add_dest", {27'd0, dest_addr_ro}, 32'd3);
        chk("add_wb", {31'd0, wb_ro}, 32'd1);

        drive(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd4, 1'b1);
        chk("add_ovf_res", res_ro, 32'h8000_0000);
        chk("add_ovf_flag", {31'd0, overflow_ro}, 32'd1);

        drive(4'b1000, 32'h8000_0000, 32'h0000_0001, 5'd5, 1'b1);
        chk("sub_ovf_res", res_ro, 32'h7FFF_FFFF);
        chk("sub_ovf_flag", {31'd0, overflow_ro}, 32'd1);

        drive(4'b1000, 32'd3, 32'd3, 5'd6, 1'b0);
        chk("sub_eq_res", res_ro, 32'd0);
        chk("sub_eq_flag", {30'd0, ops_eq_ro, overflow_ro}, 32'd2);

        drive(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b1);
        chk("slt", res_ro, 32'd1);
        drive(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd8, 1'b1);
        chk("sltu", res_ro, 32'd0);
        drive(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9, 1'b1);
        chk("xor", res_ro, 32'h0FF0_0FF0);

        drive(4'b0001, 32'h8000_0001, 32'h0000_0024, 5'd10, 1'b1);
        chk("sll", res_ro, 32'h0000_0010);
        drive(4'b0101, 32'h8000_0001, 32'h0000_0024, 5'd11, 1'b0);
        chk("srl", res_ro, 32'h0800_0000);
        drive(4'b1101, 32'h8000_0001, 32'h0000_0024, 5'd12, 1'b1);
        chk("sra", res_ro, 32'hF800_0000);

        drive(4'b1111, 32'h1234_5678, 32'h1234_5678, 5'd13, 1'b1);
        chk("bad_op_res", res_ro, 32'd0);
        chk("bad_op_tag", {25'd0, dest_addr_ro, wb_ro, ops_eq_ro, overflow_ro}, {25'd0, 5'd13, 1'b1, 1'b1, 1'b0});

        drive(4'b0110, 32'hA000_000A, 32'h0500_0050, 5'd14, 1'b0);
        chk("or", res_ro, 32'hA500_005A);
        drive(4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd15, 1'b1);
        chk("and", res_ro, 32'h0F00_0F00);

        // Back-to-back stream with distinct tags; compare process checks each cycle.
        for (int i = 0; i < 40; i++) begin
            drive_rand();
            dest_addr_i = 5'(i);
            wb_i        = i[0];
            if (i % 5 == 0) op_b_i = op_a_i;
            @(negedge clk_i);
        end

        // Asynchronous reset between edges during a stream.
        drive(4'b0000, 32'd100, 32'd23, 5'd21, 1'b1);
        sel_i = 4'b0100;
        @(posedge clk_i);
        #2 rstn_i = 1'b0;
        #1;
        chk("midrst_res", res_ro, 32'd0);
        chk("midrst_tag", {25'd0, dest_addr_ro, wb_ro, ops_eq_ro, overflow_ro}, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        drive(4'b0000, 32'd40, 32'd2, 5'd22, 1'b1);
        chk("post_rst_res", res_ro, 32'd42);
        chk("post_rst_dest", {27'd0, dest_addr_ro}, 32'd22);

        for (int i = 0; i < 20; i++) begin
            drive_rand();
            @(negedge clk_i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
